// File: rtl/oled_spi_rx.sv
`timescale 1ns/1ps
// oled_spi_rx: receive side of the OLED Pmod SPI link (SPI mode 3).
// It oversamples cs/sclk/mosi/dc/res_n in the clk domain and rebuilds bytes
// tagged command (dc=0) or data (dc=1). The bytes go into a small FIFO that
// is read through a valid/ready port.
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   oled_cs         chip select, active-low (async)
//   oled_sclk       serial clock, idles high (async)
//   oled_mosi       serial data, MSB first (async)
//   oled_dc         0 = command, 1 = data (async)
//   oled_res_n      display reset, active-low (async); flushes the FIFO
//   rx_data/rx_dc   head-of-FIFO byte and its D/C tag
//   rx_valid        FIFO not empty
//   rx_ready        consumer pops the head when rx_valid & rx_ready
//   overflow        sticky: a completed byte was dropped on a full FIFO
//   frame_err       sticky: cs rose in the middle of a byte
//   clr_err         synchronous clear of overflow and frame_err
//   byte_count      bytes accepted into the FIFO since reset (wraps)
module oled_spi_rx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oled_cs,
  input  logic        oled_sclk,
  input  logic        oled_mosi,
  input  logic        oled_dc,
  input  logic        oled_res_n,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clr_err,
  output logic [15:0] byte_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Synchronizers, reset to the idle levels of the link
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, dc_sync, res_sync;
  logic                   sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      res_sync  <= '1;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], oled_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], oled_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], oled_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], oled_dc};
      res_sync  <= {res_sync[SYNC_STAGES-2:0], oled_res_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sclk_s, mosi_s, dc_s, res_s, sclk_rise_c;
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign dc_s        = dc_sync[SYNC_STAGES-1];
  assign res_s       = res_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_prev;

  // Bit-level receive FSM
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       pend_valid;   // completed byte waiting to be pushed next cycle
  logic [7:0] pend_byte;
  logic       pend_dc;
  logic       frame_evt_c;

  // cs rising with a partial byte; a display reset never counts as a framing error
  assign frame_evt_c = (state == SHIFT) & res_s & cs_s & (bit_cnt != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      pend_valid <= 1'b0;
      pend_byte  <= 8'd0;
      pend_dc    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      frame_err  <= (frame_err & ~clr_err) | frame_evt_c;
      if (!res_s) begin
        state   <= FLUSH;
        bit_cnt <= 3'd0;
        shreg   <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            if (!cs_s) state <= SHIFT;
          end
          SHIFT: begin
            if (cs_s) begin
              state   <= IDLE;
              bit_cnt <= 3'd0;
              shreg   <= 8'd0;
            end else if (sclk_rise_c) begin
              shreg   <= {shreg[6:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                pend_valid <= 1'b1;
                pend_byte  <= {shreg[6:0], mosi_s};
                pend_dc    <= dc_s;
              end
            end
          end
          FLUSH: begin
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Byte FIFO with extra-MSB pointers
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt_c, rd_nxt_c;
  logic          full_c, pop_c, push_ok_c, ovf_evt_c;
  logic [8:0]    head_c;

  always_comb begin
    full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c     = rx_valid & rx_ready;
    // a pop in the same cycle frees the slot before the push is judged
    push_ok_c = pend_valid & res_s & (~full_c | pop_c);
    ovf_evt_c = pend_valid & res_s & full_c & ~pop_c;
    rd_nxt_c  = pop_c ? rd_ptr + PW'(1) : rd_ptr;
    wr_nxt_c  = push_ok_c ? wr_ptr + PW'(1) : wr_ptr;
    // an empty-after-pop FIFO takes its new head straight from the push
    head_c    = (rd_nxt_c == wr_ptr) ? {pend_dc, pend_byte} : mem[rd_nxt_c[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr[AW-1:0]] <= {pend_dc, pend_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'd0;
      rx_dc      <= 1'b0;
      byte_count <= 16'd0;
      overflow   <= 1'b0;
    end else begin
      overflow <= (overflow & ~clr_err) | ovf_evt_c;
      if (!res_s) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        rx_valid <= 1'b0;
      end else begin
        wr_ptr   <= wr_nxt_c;
        rd_ptr   <= rd_nxt_c;
        rx_valid <= (wr_nxt_c != rd_nxt_c);
        if (wr_nxt_c != rd_nxt_c) {rx_dc, rx_data} <= head_c;
        if (push_ok_c) byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
`timescale 1ns/1ps
// tb_oled_spi_rx: directed bench for oled_spi_rx. The SPI master is bit-banged
// at 4 clk cycles per sclk phase. Each expected byte goes into a queue when
// it is sent, and is popped and compared when the DUT presents it.
module tb_oled_spi_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        oled_cs, oled_sclk, oled_mosi, oled_dc, oled_res_n;
  logic [7:0]  rx_data;
  logic        rx_dc, rx_valid, rx_ready;
  logic        overflow, frame_err, clr_err;
  logic [15:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q [$];

  oled_spi_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .oled_cs(oled_cs), .oled_sclk(oled_sclk), .oled_mosi(oled_mosi),
    .oled_dc(oled_dc), .oled_res_n(oled_res_n),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overflow(overflow), .frame_err(frame_err), .clr_err(clr_err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // advance n rising edges, then step 1 ns past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // falling edge with new data, low phase, then rising edge (caller holds high)
  task automatic spi_bit(input logic b, input logic dc);
    oled_sclk = 1'b0;
    oled_mosi = b;
    oled_dc   = dc;
    tick(4);
    oled_sclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], dc);
      tick(4);
    end
  endtask

  // compare the head against the scoreboard, then pop it with a one-cycle ready
  task automatic pop_check(input string tag);
    logic [8:0] e;
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed entry 0x%0h expected none queued", tag, {rx_dc, rx_data});
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'({rx_dc, rx_data}), 32'(e));
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    oled_cs = 1'b1; oled_sclk = 1'b1; oled_mosi = 1'b0; oled_dc = 1'b0;
    oled_res_n = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] burst [6];
    logic       burst_dc [6];
    burst    = '{8'h15, 8'h00, 8'h5F, 8'hF8, 8'h1F, 8'hAA};
    burst_dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // reset values
    do_reset();
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_dc", 32'(rx_dc), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);

    // single command 0xAF with rx_valid latency after the 8th rising edge
    oled_cs = 1'b0; tick(4);
    exp_q.push_back({1'b0, 8'hAF});
    for (int i = 7; i >= 1; i--) begin
      spi_bit(1'(8'hAF >> i), 1'b0);
      tick(4);
    end
    spi_bit(1'b1, 1'b0);
    tick(3);
    check("lat_3cyc", 32'(rx_valid), 32'd0);
    tick(1);
    check("lat_4cyc", 32'(rx_valid), 32'd1);
    oled_cs = 1'b1; tick(4);
    check("cmd_count", 32'(byte_count), 32'd1);
    check("cmd_ferr", 32'(frame_err), 32'd0);
    check("cmd_ovf", 32'(overflow), 32'd0);
    pop_check("cmd");
    check("cmd_empty", 32'(rx_valid), 32'd0);

    // burst of six bytes, mixed command/data tags
    do_reset();
    oled_cs = 1'b0; tick(4);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({burst_dc[k], burst[k]});
      send_byte(burst[k], burst_dc[k]);
      pop_check("burst");
    end
    oled_cs = 1'b1; tick(4);
    check("burst_count", 32'(byte_count), 32'd6);
    check("burst_empty", 32'(rx_valid), 32'd0);

    // overflow: five bytes into a depth-4 FIFO with no reads
    do_reset();
    oled_cs = 1'b0; tick(4);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back({1'b1, 8'(8'h30 + k)});
      send_byte(8'(8'h30 + k), 1'b1);
    end
    oled_cs = 1'b1; tick(4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(byte_count), 32'd4);
    for (int k = 0; k < 4; k++) pop_check("ovf_drain");
    check("ovf_empty", 32'(rx_valid), 32'd0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // partial frame of 5 bits, then a good byte, then clear
    do_reset();
    oled_cs = 1'b0; tick(4);
    for (int i = 7; i >= 3; i--) begin
      spi_bit(1'b1, 1'b0);
      tick(4);
    end
    oled_cs = 1'b1; tick(6);
    check("part_ferr", 32'(frame_err), 32'd1);
    check("part_nopush", 32'(rx_valid), 32'd0);
    check("part_count", 32'(byte_count), 32'd0);
    oled_cs = 1'b0; tick(4);
    exp_q.push_back({1'b0, 8'h3C});
    send_byte(8'h3C, 1'b0);
    oled_cs = 1'b1; tick(4);
    pop_check("part_next");
    check("part_count2", 32'(byte_count), 32'd1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("part_clr", 32'(frame_err), 32'd0);

    // full FIFO: pop and push land on the same edge
    do_reset();
    oled_cs = 1'b0; tick(4);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 8'(8'h11 * (k + 1))});
      send_byte(8'(8'h11 * (k + 1)), 1'b0);
    end
    exp_q.push_back({1'b1, 8'h55});
    for (int i = 7; i >= 1; i--) begin
      spi_bit(1'(8'h55 >> i), 1'b1);
      tick(4);
    end
    spi_bit(1'b1, 1'b1);
    tick(3);
    pop_check("simul_pop");
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_count", 32'(byte_count), 32'd5);
    for (int k = 0; k < 4; k++) pop_check("simul_drain");
    check("simul_empty", 32'(rx_valid), 32'd0);
    oled_cs = 1'b1; tick(4);

    // display reset mid-byte with two bytes queued
    do_reset();
    oled_cs = 1'b0; tick(4);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b1);
    for (int i = 7; i >= 5; i--) begin
      spi_bit(1'b0, 1'b0);
      tick(4);
    end
    oled_res_n = 1'b0; tick(4);
    oled_res_n = 1'b1; tick(4);
    check("res_valid", 32'(rx_valid), 32'd0);
    check("res_ferr", 32'(frame_err), 32'd0);
    check("res_count", 32'(byte_count), 32'd2);
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A, 1'b1);
    pop_check("res_next");
    oled_cs = 1'b1; tick(6);
    check("res_ferr2", 32'(frame_err), 32'd0);
    check("res_count2", 32'(byte_count), 32'd3);

    // asynchronous reset in the middle of a byte
    do_reset();
    oled_cs = 1'b0; tick(4);
    send_byte(8'h81, 1'b1);
    check("arst_pre", 32'({rx_dc, rx_data}), 32'h181);
    for (int i = 7; i >= 5; i--) begin
      spi_bit(1'b1, 1'b1);
      tick(4);
    end
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(rx_valid), 32'd0);
    check("arst_data", 32'(rx_data), 32'd0);
    check("arst_dc", 32'(rx_dc), 32'd0);
    check("arst_count", 32'(byte_count), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_ferr", 32'(frame_err), 32'd0);
    oled_cs = 1'b1; oled_sclk = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    check("arst_ferr2", 32'(frame_err), 32'd0);
    check("arst_valid2", 32'(rx_valid), 32'd0);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
